// File: rtl/arb_pkg.sv
// Shared definitions for the arbitrated requester: default sizing and FSM states.
// Optional feature macro: ARB_REQ_BURST_LIMIT_EN (adds the YIELD state).
package arb_pkg;

  localparam int ARB_DW        = 8;
  localparam int ARB_DEPTH     = 4;
  localparam int ARB_MAX_BURST = 4;

  // Requester FSM; YIELD only exists when the burst limit is compiled in.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
`ifdef ARB_REQ_BURST_LIMIT_EN
    ST_XFER  = 2'd2,
    ST_YIELD = 2'd3
`else
    ST_XFER  = 2'd2
`endif
  } state_t;

endpackage

// File: rtl/arb_requester_if.sv
// Arbiter/bus side of one requester lane: request, grant and the transfer bus.
interface arb_requester_if
  import arb_pkg::*;
#(
  parameter int DW = ARB_DW
) ();

  logic          req;
  logic          grant;
  logic          bus_valid;
  logic [DW-1:0] bus_data;

  // The requester drives req and the bus; the arbiter/bus side returns grant.
  modport master (output req, output bus_valid, output bus_data, input grant);
  modport slave  (input req, input bus_valid, input bus_data, output grant);

endinterface

// File: rtl/arb_req_fifo.sv
// Circular word queue for the requester: storage, wrapping pointers, occupancy,
// full flag and a sticky overflow flag for dropped writes.
module arb_req_fifo
  import arb_pkg::*;
#(
  parameter int DW    = ARB_DW,
  parameter int DEPTH = ARB_DEPTH,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr_en,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_pop,
  output logic          o_push,
  output logic [DW-1:0] o_head,
  output logic [LW-1:0] o_level,
  output logic          o_full,
  output logic          o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_overflow;
  logic          w_full;
  logic          w_push;

  assign w_full     = (r_level == LW'(DEPTH));
  // A full queue still accepts a write when the head leaves in the same cycle.
  assign w_push     = i_wr_en & (~w_full | i_pop);

  assign o_push     = w_push;
  assign o_head     = r_mem[r_rd_ptr];
  assign o_level    = r_level;
  assign o_full     = w_full;
  assign o_overflow = r_overflow;

  // Storage write; contents are not reset, the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers (power-of-two depth wraps naturally), occupancy and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !i_pop) begin
        r_level <= r_level + LW'(1);
      end else if (!w_push && i_pop) begin
        r_level <= r_level - LW'(1);
      end
      if (i_wr_en && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_requester.sv
// One requester lane of a round-robin arbiter: queues producer words and
// requests the bus while words are pending, popping one word per granted cycle.
// Optional feature macro: ARB_REQ_BURST_LIMIT_EN -- yield the request for one
// cycle after MAX_BURST words have been sent under one grant.
module arb_requester
  import arb_pkg::*;
#(
  parameter int DW        = ARB_DW,
  parameter int DEPTH     = ARB_DEPTH,
  parameter int MAX_BURST = ARB_MAX_BURST
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [DW-1:0]            wr_data,
  output logic                     full,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level,
  arb_requester_if.master          bus
);

  localparam int LW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_BURST < 1) begin : g_bad_cfg
    $error("arb_requester: DEPTH must be a power of two >= 2 and MAX_BURST >= 1");
  end

  state_t        r_state;
  logic          r_req;
  logic          w_push;
  logic          w_pop;
  logic [LW-1:0] w_level;
  logic [LW-1:0] w_level_after;
  logic          w_has_after;

  arb_req_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_en    (wr_en),
    .i_wr_data  (wr_data),
    .i_pop      (w_pop),
    .o_push     (w_push),
    .o_head     (bus.bus_data),
    .o_level    (w_level),
    .o_full     (full),
    .o_overflow (overflow)
  );

  // Grant only counts while requesting and a word is actually queued.
  assign w_pop         = bus.grant & r_req & (w_level != '0);
  assign bus.bus_valid = w_pop;
  assign bus.req       = r_req;
  assign level         = w_level;

  // Occupancy after this edge; lets IDLE raise req one cycle after the write.
  always_comb begin
    w_level_after = w_level;
    if (w_push && !w_pop) begin
      w_level_after = w_level + LW'(1);
    end else if (!w_push && w_pop) begin
      w_level_after = w_level - LW'(1);
    end
  end
  assign w_has_after = (w_level_after != '0);

`ifdef ARB_REQ_BURST_LIMIT_EN
  localparam int BCW = $clog2(MAX_BURST) + 1;
  logic [BCW-1:0] r_burst;

  // Request FSM with burst counting; req is registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_burst <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_has_after) begin
            r_state <= ST_REQ;
            r_req   <= 1'b1;
          end
        end
        ST_REQ, ST_XFER: begin
          if (w_pop) begin
            if (!w_has_after) begin
              r_state <= ST_IDLE;
              r_req   <= 1'b0;
              r_burst <= '0;
            end else if (r_burst == BCW'(MAX_BURST - 1)) begin
              r_state <= ST_YIELD;
              r_req   <= 1'b0;
              r_burst <= '0;
            end else begin
              r_state <= ST_XFER;
              r_burst <= r_burst + BCW'(1);
            end
          end else if (r_state == ST_XFER) begin
            // Grant fell with words left: re-request and start a fresh burst.
            r_state <= ST_REQ;
            r_burst <= '0;
          end
        end
        ST_YIELD: begin
          r_state <= w_has_after ? ST_REQ : ST_IDLE;
          r_req   <= w_has_after;
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
          r_burst <= '0;
        end
      endcase
    end
  end
`else
  // Request FSM; req is registered alongside the state and held while non-empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_has_after) begin
            r_state <= ST_REQ;
            r_req   <= 1'b1;
          end
        end
        ST_REQ, ST_XFER: begin
          if (w_pop) begin
            r_state <= w_has_after ? ST_XFER : ST_IDLE;
            r_req   <= w_has_after;
          end else if (r_state == ST_XFER) begin
            r_state <= ST_REQ;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_arb_requester.sv
// Directed testbench for arb_requester (DW=8, DEPTH=4, MAX_BURST=4).
// Builds with or without ARB_REQ_BURST_LIMIT_EN; the burst test picks its
// expected sequence accordingly.
module tb_arb_requester;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       overflow;
  logic [2:0] level;

  int n_checks;
  int n_fail;

  arb_requester_if #(.DW(8)) u_if ();

  arb_requester #(
    .DW        (8),
    .DEPTH     (4),
    .MAX_BURST (4)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .overflow (overflow),
    .level    (level),
    .bus      (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven from here.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  logic       exp_v [8];
  logic       exp_r [8];
  logic [7:0] exp_d [8];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    wr_en    = 1'b0;
    wr_data  = 8'h00;
    u_if.grant = 1'b0;
`ifdef ARB_REQ_BURST_LIMIT_EN
    exp_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_r = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h00, 8'h14, 8'h15, 8'h00};
`else
    exp_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_r = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h00, 8'h00};
`endif

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check_val("rst_req", 32'(u_if.req), 32'd0);
    check_val("rst_bus_valid", 32'(u_if.bus_valid), 32'd0);
    check_val("rst_full", 32'(full), 32'd0);
    check_val("rst_level", 32'(level), 32'd0);
    check_val("rst_overflow", 32'(overflow), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Single word: write A5, req next cycle, grant transfers, then IDLE
    cyc(); wr_en = 1'b1; wr_data = 8'hA5; #1;
    check_val("c0_req", 32'(u_if.req), 32'd0);
    cyc(); wr_en = 1'b0; #1;
    check_val("c1_req", 32'(u_if.req), 32'd1);
    check_val("c1_level", 32'(level), 32'd1);
    cyc(); u_if.grant = 1'b1; #1;
    check_val("c2_bus_valid", 32'(u_if.bus_valid), 32'd1);
    check_val("c2_bus_data", 32'(u_if.bus_data), 32'hA5);
    cyc(); #1;  // trailing grant past empty
    check_val("c3_req", 32'(u_if.req), 32'd0);
    check_val("c3_trail_valid", 32'(u_if.bus_valid), 32'd0);
    check_val("c3_level", 32'(level), 32'd0);
    cyc(); u_if.grant = 1'b0; #1;
    check_val("c4_idle_req", 32'(u_if.req), 32'd0);

    // Overflow: five writes into a four-deep queue, no grant
    for (int i = 0; i < 5; i++) begin
      cyc(); wr_en = 1'b1; wr_data = 8'(i + 1); #1;
      if (i == 4) begin
        check_val("ovf_full_pre", 32'(full), 32'd1);
        check_val("ovf_flag_pre", 32'(overflow), 32'd0);
      end
    end
    cyc(); wr_en = 1'b0; #1;
    check_val("ovf_full", 32'(full), 32'd1);
    check_val("ovf_flag", 32'(overflow), 32'd1);
    check_val("ovf_level", 32'(level), 32'd4);
    check_val("ovf_req", 32'(u_if.req), 32'd1);

    // Partial grant: two pops in order, req stays up
    cyc(); u_if.grant = 1'b1; #1;
    check_val("pg_valid0", 32'(u_if.bus_valid), 32'd1);
    check_val("pg_data0", 32'(u_if.bus_data), 32'h01);
    cyc(); #1;
    check_val("pg_data1", 32'(u_if.bus_data), 32'h02);
    cyc(); u_if.grant = 1'b0; #1;
    check_val("pg_valid_off", 32'(u_if.bus_valid), 32'd0);
    check_val("pg_req", 32'(u_if.req), 32'd1);
    check_val("pg_level", 32'(level), 32'd2);

    // Refill, then simultaneous write and pop while full
    cyc(); wr_en = 1'b1; wr_data = 8'h05;
    cyc(); wr_data = 8'h06;
    cyc(); wr_data = 8'h07; u_if.grant = 1'b1; #1;
    check_val("sim_full", 32'(full), 32'd1);
    check_val("sim_data", 32'(u_if.bus_data), 32'h03);
    cyc(); wr_en = 1'b0; #1;
    check_val("sim_level", 32'(level), 32'd4);
    check_val("sim_data_next", 32'(u_if.bus_data), 32'h04);
    check_val("sim_ovf_sticky", 32'(overflow), 32'd1);
    cyc(); #1;
    check_val("xfer_level3", 32'(level), 32'd3);

    // Asynchronous reset mid-transfer
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_req", 32'(u_if.req), 32'd0);
    check_val("arst_valid", 32'(u_if.bus_valid), 32'd0);
    check_val("arst_level", 32'(level), 32'd0);
    check_val("arst_ovf", 32'(overflow), 32'd0);
    cyc(); #1;
    check_val("arst_hold_valid", 32'(u_if.bus_valid), 32'd0);
    #2 rst_n = 1'b1;
    cyc(); #1;
    check_val("post_rst_valid", 32'(u_if.bus_valid), 32'd0);
    check_val("post_rst_req", 32'(u_if.req), 32'd0);
    u_if.grant = 1'b0;

    // Burst: four queued plus two written during the first pops, grant held
    for (int i = 0; i < 4; i++) begin
      cyc(); wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
    end
    cyc(); wr_en = 1'b0; #1;
    check_val("bst_level", 32'(level), 32'd4);
    for (int i = 0; i < 8; i++) begin
      cyc();
      u_if.grant = 1'b1;
      wr_en   = (i < 2);
      wr_data = 8'h14 + 8'(i);
      #1;
      check_val($sformatf("bst_req%0d", i), 32'(u_if.req), 32'(exp_r[i]));
      check_val($sformatf("bst_valid%0d", i), 32'(u_if.bus_valid), 32'(exp_v[i]));
      if (exp_v[i]) begin
        check_val($sformatf("bst_data%0d", i), 32'(u_if.bus_data), 32'(exp_d[i]));
      end
    end
    cyc(); u_if.grant = 1'b0; wr_en = 1'b0; #1;
    check_val("bst_end_level", 32'(level), 32'd0);
    check_val("bst_end_ovf", 32'(overflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arb_requester.md
ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 SHALL have parameter DW, default 8: width of each queued data word.
REQ-002 SHALL have parameter DEPTH, default 4: queue depth in words; power of two, minimum 2.
REQ-003 SHALL have parameter MAX_BURST, default 4: words sent per grant before yielding (used only under REQ-025).
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port wr_en  input  1  producer write strobe.
REQ-007 SHALL have port wr_data  input  DW  producer write word.
REQ-008 SHALL have port full  output  1  queue holds DEPTH words.
REQ-009 SHALL have port overflow  output  1  sticky: a write was dropped.
REQ-010 SHALL have port req  output  1  request to the round-robin arbiter, one requester lane.
REQ-011 SHALL have port grant  input  1  this lane's one-hot grant bit from the arbiter.
REQ-012 SHALL have port bus_valid  output  1  word on bus_data is transferred this cycle.
REQ-013 SHALL have port bus_data  output  DW  head-of-queue word.
REQ-014 SHALL have port level  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-015 SHALL implement a circular FIFO; a write is accepted when wr_en and (not full, or a pop occurs in the same cycle).
REQ-016 SHALL drop a write when full with no same-cycle pop, and set overflow; overflow clears only on reset.
REQ-017 SHALL implement FSM states IDLE, REQ, XFER, plus YIELD when REQ-025 applies; req = 1 exactly in REQ and XFER.
REQ-018 SHALL transition IDLE->REQ on the first edge at which level != 0, so req rises one cycle after the first accepted write.
REQ-019 SHALL transition REQ->XFER on the edge where grant = 1; grant seen in REQ already transfers a word in that cycle.
REQ-020 SHALL drive bus_valid = grant & req & (level != 0), combinationally; each bus_valid cycle pops exactly one word, and bus_data is the head word.
REQ-021 SHALL, in XFER, go to REQ if grant falls while words remain, and to IDLE when the queue empties.
REQ-022 SHALL ignore grant while req = 0; the arbiter's grant lags req by one cycle, so one trailing grant cycle after release produces no transfer.
REQ-023 SHALL handle a simultaneous write and pop by leaving level unchanged and keeping the FSM state.
REQ-024 SHALL wrap read and write pointers modulo DEPTH, and SHALL never let level exceed DEPTH.

Configuration
REQ-025 SHALL, when ARB_REQ_BURST_LIMIT_EN is defined, count pops in XFER; after MAX_BURST pops it enters YIELD (req = 0) for exactly one cycle, then goes to REQ if level != 0, else to IDLE.
REQ-026 SHALL, without ARB_REQ_BURST_LIMIT_EN, hold req for as long as the queue is non-empty; YIELD and the burst counter are then absent.

Reset
REQ-027 SHALL, while rst_n = 0, force state IDLE, pointers 0, level 0, overflow 0 and burst count 0 immediately, regardless of clk.
REQ-028 SHALL hold req = 0, bus_valid = 0 and full = 0 during reset; bus_data is don't-care.
REQ-029 SHALL discard queued words on a reset applied mid-transfer; no word is presented after reset until a new write.

Structure
REQ-030 SHALL place the FSM state enum and the default DW, DEPTH and MAX_BURST constants in the shared package arb_pkg.
REQ-031 SHALL implement the queue as a sub-module arb_req_fifo (storage, pointers, level, full); the FSM and burst logic stay in arb_requester.

Verification
REQ-032 SHALL cover: write 0xA5 in cycle 0 -> req = 1 in cycle 1; grant in cycle 2 -> bus_valid = 1 with bus_data = 0xA5 in cycle 2; req = 0 and state IDLE in cycle 3.
REQ-033 SHALL cover: 5 writes with DEPTH = 4 and no grant -> full = 1 after 4 writes, 5th word dropped, overflow = 1, level = 4.
REQ-034 SHALL cover: 4 words queued, grant held 2 cycles then low -> 2 pops in order, req stays 1, level = 2.
REQ-035 SHALL cover: grant held 1 cycle past queue empty -> bus_valid = 0 in that cycle, level stays 0.
REQ-036 SHALL cover: with ARB_REQ_BURST_LIMIT_EN, 6 words queued and grant held -> 4 pops, req = 0 for 1 cycle, then req = 1 and 2 more pops.
REQ-037 SHALL cover: rst_n low mid-XFER with level = 3 -> req, bus_valid and level read 0 asynchronously, before the next clk edge.
